// File: rtl/usbf_ep_tx_fifo_pkg.sv
// Shared constants for the IN-endpoint transmit FIFO: state encodings and width aliases.
package usbf_ep_tx_fifo_pkg;

  localparam int USB_EP0_DATA_DATA_W      = 8;
  localparam int USB_EP0_TX_CTRL_TX_LEN_W = 11;

  typedef enum logic [1:0] {
    USB_TXF_IDLE     = 2'd0,
    USB_TXF_ARMED    = 2'd1,
    USB_TXF_STREAM   = 2'd2,
    USB_TXF_WAIT_ACK = 2'd3
  } txf_state_e;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/usbf_ep_tx_fifo_mem.sv
// Packet byte storage: synchronous write, asynchronous read, contents not reset.
module usbf_fifo_mem #(
  parameter int DW    = 8,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem[rd_addr_i];

endmodule

// File: rtl/usbf_ep_tx_fifo.sv
// Phy-domain transmit buffer for one IN endpoint; holds each packet until ACK so retries replay it.
//
// state    | meaning
// IDLE     | no packet armed; tx_start_i checks length against committed level
// ARMED    | packet armed, waiting for an IN token
// STREAM   | presenting bytes to the packet engine
// WAIT_ACK | packet sent; ACK commits it, retry rewinds to the packet start
module usbf_ep_tx_fifo
  import usbf_ep_tx_fifo_pkg::*;
#(
  parameter int DW    = USB_EP0_DATA_DATA_W,
  parameter int DEPTH = 64,
  parameter int LW    = USB_EP0_TX_CTRL_TX_LEN_W
) (
  input  logic                       phy_clk_i,
  input  logic                       rstn_i,
  input  logic                       wt_req_i,
  input  logic [DW-1:0]              wt_data_i,
  input  logic                       flush_i,
  input  logic                       tx_start_i,
  input  logic [LW-1:0]              tx_len_i,
  input  logic                       token_i,
  input  logic                       data_ready_i,
  input  logic                       ack_i,
  input  logic                       retry_i,
  output logic                       data_valid_o,
  output logic [DW-1:0]              data_o,
  output logic                       data_last_o,
  output logic                       pkt_end_o,
  output logic                       tx_busy_o,
  output logic                       tx_err_o,
  output logic                       tx_complete_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = max_w(LW, PW);

  txf_state_e    state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] pkt_start_q, pkt_start_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] remaining_q, remaining_d;
  logic          tx_busy_q, tx_busy_d;
  logic          tx_err_q, tx_err_d;
  logic          pkt_end_q, pkt_end_d;
  logic          tx_complete_q, tx_complete_d;

  logic [PW-1:0] level;
  logic          full;
  logic          wr_en;
  logic          len_too_big;
  logic          streaming;

  // Space is reclaimed only on ACK, so level is measured from the commit pointer.
  assign level       = wr_ptr_q - commit_ptr_q;
  assign full        = (level == PW'(DEPTH));
  assign wr_en       = wt_req_i & ~flush_i & ~full;
  assign len_too_big = CW'(tx_len_i) > CW'(level);
  assign streaming   = (state_q == USB_TXF_STREAM);

  usbf_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i     (phy_clk_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (wt_data_i),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (data_o)
  );

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    commit_ptr_d  = commit_ptr_q;
    pkt_start_d   = pkt_start_q;
    len_d         = len_q;
    remaining_d   = remaining_q;
    tx_busy_d     = tx_busy_q;
    tx_err_d      = tx_err_q;
    pkt_end_d     = 1'b0;
    tx_complete_d = 1'b0;

    if (flush_i) begin
      state_d      = USB_TXF_IDLE;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      commit_ptr_d = '0;
      pkt_start_d  = '0;
      remaining_d  = '0;
      tx_busy_d    = 1'b0;
      tx_err_d     = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);

      unique case (state_q)
        USB_TXF_IDLE: begin
          if (tx_start_i) begin
            len_d    = tx_len_i;
            tx_err_d = 1'b0;
            if (len_too_big) begin
              tx_err_d = 1'b1;
            end else begin
              pkt_start_d = rd_ptr_q;
              tx_busy_d   = 1'b1;
              state_d     = USB_TXF_ARMED;
            end
          end
        end
        USB_TXF_ARMED: begin
          if (token_i) begin
            if (len_q == '0) begin
              pkt_end_d = 1'b1;
              state_d   = USB_TXF_WAIT_ACK;
            end else begin
              remaining_d = len_q;
              state_d     = USB_TXF_STREAM;
            end
          end
        end
        USB_TXF_STREAM: begin
          if (data_ready_i) begin
            rd_ptr_d    = rd_ptr_q + PW'(1);
            remaining_d = remaining_q - LW'(1);
            if (remaining_q == LW'(1)) begin
              pkt_end_d = 1'b1;
              state_d   = USB_TXF_WAIT_ACK;
            end
          end
        end
        USB_TXF_WAIT_ACK: begin
          if (ack_i) begin
            commit_ptr_d  = rd_ptr_q;
            tx_complete_d = 1'b1;
            tx_busy_d     = 1'b0;
            state_d       = USB_TXF_IDLE;
          end else if (retry_i) begin
            rd_ptr_d = pkt_start_q;
            state_d  = USB_TXF_ARMED;
          end
        end
        default: state_d = USB_TXF_IDLE;
      endcase

      // An overflowing write flags an error even if a start clears it this cycle.
      if (wt_req_i && full) tx_err_d = 1'b1;
    end
  end

  always_ff @(posedge phy_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= USB_TXF_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      commit_ptr_q  <= '0;
      pkt_start_q   <= '0;
      len_q         <= '0;
      remaining_q   <= '0;
      tx_busy_q     <= 1'b0;
      tx_err_q      <= 1'b0;
      pkt_end_q     <= 1'b0;
      tx_complete_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      commit_ptr_q  <= commit_ptr_d;
      pkt_start_q   <= pkt_start_d;
      len_q         <= len_d;
      remaining_q   <= remaining_d;
      tx_busy_q     <= tx_busy_d;
      tx_err_q      <= tx_err_d;
      pkt_end_q     <= pkt_end_d;
      tx_complete_q <= tx_complete_d;
    end
  end

  assign data_valid_o  = streaming;
  assign data_last_o   = streaming && (remaining_q == LW'(1));
  assign pkt_end_o     = pkt_end_q;
  assign tx_busy_o     = tx_busy_q;
  assign tx_err_o      = tx_err_q;
  assign tx_complete_o = tx_complete_q;
  assign level_o       = level;

endmodule

// File: tb/tb_usbf_ep_tx_fifo.sv
// Bench for usbf_ep_tx_fifo: directed scenarios plus random strobes against a queue-based packet model.
module tb_usbf_ep_tx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam int LW    = 11;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wt_req, flush, tx_start, token, data_ready, ack, retry;
  logic [DW-1:0] wt_data;
  logic [LW-1:0] tx_len;
  logic          data_valid, data_last, pkt_end, tx_busy, tx_err, tx_complete;
  logic [DW-1:0] data;
  logic [6:0]    level;

  int total = 0;
  int bad   = 0;

  // Model: bytes held from the oldest unacknowledged one onward, plus packet progress.
  byte unsigned m_q[$];
  int           m_phase;  // 0 idle, 1 armed, 2 sending, 3 awaiting ack
  int           m_len;
  int           m_pos;
  bit           m_busy, m_err, m_pkt_end, m_complete;

  always #5 clk = ~clk;

  usbf_ep_tx_fifo #(.DW(DW), .DEPTH(DEPTH), .LW(LW)) dut (
    .phy_clk_i     (clk),
    .rstn_i        (rstn),
    .wt_req_i      (wt_req),
    .wt_data_i     (wt_data),
    .flush_i       (flush),
    .tx_start_i    (tx_start),
    .tx_len_i      (tx_len),
    .token_i       (token),
    .data_ready_i  (data_ready),
    .ack_i         (ack),
    .retry_i       (retry),
    .data_valid_o  (data_valid),
    .data_o        (data),
    .data_last_o   (data_last),
    .pkt_end_o     (pkt_end),
    .tx_busy_o     (tx_busy),
    .tx_err_o      (tx_err),
    .tx_complete_o (tx_complete),
    .level_o       (level)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("valid", 32'(data_valid), 32'(m_phase == 2));
    if (m_phase == 2) begin
      chk("data", 32'(data), 32'(m_q[m_pos]));
      chk("last", 32'(data_last), 32'(m_pos == m_len - 1));
    end
    chk("pkt_end", 32'(pkt_end), 32'(m_pkt_end));
    chk("complete", 32'(tx_complete), 32'(m_complete));
    chk("busy", 32'(tx_busy), 32'(m_busy));
    chk("err", 32'(tx_err), 32'(m_err));
    chk("level", 32'(level), 32'(m_q.size()));
  endtask

  task automatic model_step();
    int lvl = m_q.size();
    m_pkt_end  = 0;
    m_complete = 0;
    if (flush) begin
      m_q.delete();
      m_phase = 0;
      m_pos   = 0;
      m_busy  = 0;
      m_err   = 0;
    end else begin
      case (m_phase)
        0: if (tx_start) begin
          m_len = int'(tx_len);
          m_err = 0;
          if (m_len > lvl) m_err = 1;
          else begin
            m_busy  = 1;
            m_phase = 1;
            m_pos   = 0;
          end
        end
        1: if (token) begin
          if (m_len == 0) begin
            m_pkt_end = 1;
            m_phase   = 3;
          end else m_phase = 2;
        end
        2: if (data_ready) begin
          m_pos++;
          if (m_pos == m_len) begin
            m_pkt_end = 1;
            m_phase   = 3;
          end
        end
        default: if (ack) begin
          for (int i = 0; i < m_len; i++) void'(m_q.pop_front());
          m_complete = 1;
          m_busy     = 0;
          m_phase    = 0;
        end else if (retry) begin
          m_pos   = 0;
          m_phase = 1;
        end
      endcase
      if (wt_req) begin
        if (lvl >= DEPTH) m_err = 1;
        else m_q.push_back(wt_data);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
    wt_req   = 0;
    flush    = 0;
    tx_start = 0;
    token    = 0;
    ack      = 0;
    retry    = 0;
  endtask

  task automatic wr(input logic [7:0] b);
    wt_req  = 1;
    wt_data = b;
    tick();
  endtask

  task automatic start(input int len);
    tx_start = 1;
    tx_len   = LW'(len);
    tick();
  endtask

  task automatic run_packet(input bit rand_ready);
    int n = 0;
    token      = 1;
    data_ready = 1;
    tick();
    while (m_phase == 2 && n < 300) begin
      data_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    chk("stream_timeout", 32'(n < 300), 32'd1);
    data_ready = 1;
    tick();
  endtask

  task automatic do_ack(input bit with_write, input logic [7:0] b);
    ack = 1;
    if (with_write) begin
      wt_req  = 1;
      wt_data = b;
    end
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 0;
    {wt_req, flush, tx_start, token, data_ready, ack, retry} = '0;
    wt_data = '0;
    tx_len  = '0;
    m_phase = 0; m_len = 0; m_pos = 0;
    m_busy = 0; m_err = 0; m_pkt_end = 0; m_complete = 0;
    repeat (2) @(negedge clk);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_err", 32'(tx_err), 32'd0);
    chk("rst_pkt_end", 32'(pkt_end), 32'd0);
    chk("rst_complete", 32'(tx_complete), 32'd0);
    @(posedge clk);
    #1 rstn = 1;
    data_ready = 1;

    // Basic packet, ack commit
    for (int i = 0; i < 5; i++) wr(8'hA0 + 8'(i));
    start(5);
    chk("s1_busy", 32'(tx_busy), 32'd1);
    run_packet(0);
    chk("s1_level_pre", 32'(level), 32'd5);
    do_ack(0, 8'h00);
    chk("s1_level_post", 32'(level), 32'd0);

    // Retry replays the same bytes
    for (int i = 0; i < 5; i++) wr(8'hB0 + 8'(i));
    start(5);
    run_packet(0);
    retry = 1;
    tick();
    chk("s2_level_retry", 32'(level), 32'd5);
    run_packet(1);
    do_ack(0, 8'h00);
    chk("s2_level_post", 32'(level), 32'd0);

    // Too-long request errors, then a valid one arms
    for (int i = 0; i < 3; i++) wr(8'hC0 + 8'(i));
    start(4);
    chk("s3_err", 32'(tx_err), 32'd1);
    chk("s3_busy", 32'(tx_busy), 32'd0);
    start(3);
    chk("s3_err_clr", 32'(tx_err), 32'd0);
    run_packet(0);
    do_ack(0, 8'h00);

    // Zero-length packet
    start(0);
    run_packet(0);
    do_ack(0, 8'h00);

    // Fill, overflow, flush mid-stream
    for (int i = 0; i < DEPTH; i++) wr(8'($urandom));
    wr(8'hEE);
    chk("s5_err", 32'(tx_err), 32'd1);
    chk("s5_level", 32'(level), 32'd64);
    start(10);
    token = 1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    flush = 1;
    tick();
    chk("s5_flush_level", 32'(level), 32'd0);
    chk("s5_flush_busy", 32'(tx_busy), 32'd0);
    tick();

    // Wrap-around with stalls and writes during ack
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < 7; i++) wr(8'($urandom));
      start(7);
      run_packet(1);
      do_ack(1, 8'($urandom));
    end

    // Random strobe soup, including ignored and colliding strobes
    for (int c = 0; c < 2000; c++) begin
      wt_req     = ($urandom_range(0, 99) < 35);
      wt_data    = 8'($urandom);
      tx_start   = ($urandom_range(0, 99) < 12);
      tx_len     = ($urandom_range(0, 9) == 0) ? LW'($urandom_range(0, 80)) : LW'($urandom_range(0, 12));
      token      = ($urandom_range(0, 99) < 15);
      data_ready = ($urandom_range(0, 99) < 70);
      ack        = ($urandom_range(0, 99) < 10);
      retry      = ($urandom_range(0, 99) < 8);
      flush      = ($urandom_range(0, 199) == 0);
      tick();
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
